// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execution-stage ALU with a registered result and zero flag.
// Logical and arithmetic ops complete in one cycle. SLL/SRL use an iterative
// shifter that moves one bit per cycle, with a start/busy/done handshake.
// Optional feature: define ALU_OVF_EN to add the signed-overflow output 'ovf'.
module alu_exec_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       ALUSignal,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   shamt,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic             illegal
`ifdef ALU_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam logic [3:0] OpAnd = 4'b0000;
   localparam logic [3:0] OpOr  = 4'b0001;
   localparam logic [3:0] OpAdd = 4'b0010;
   localparam logic [3:0] OpSub = 4'b0110;
   localparam logic [3:0] OpSlt = 4'b0111;
   localparam logic [3:0] OpSll = 4'b1000;
   localparam logic [3:0] OpSrl = 4'b1001;

   typedef enum logic {StIdle, StShift} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             dir_q, dir_d;     // 1: shift right (SRL)
   logic [WIDTH-1:0] result_d;
   logic             zero_d, busy_d, done_d, illegal_d;

   logic [WIDTH-1:0] sum, diff, op_res, shifted;
   logic             op_ill, is_shift;

`ifdef ALU_OVF_EN
   logic ovf_d, op_ovf;
`endif

   assign sum      = a + b;
   assign diff     = a - b;
   assign is_shift = (ALUSignal == OpSll) || (ALUSignal == OpSrl);
   assign shifted  = dir_q ? (sreg_q >> 1) : (sreg_q << 1);

   // Single-cycle result for the op presented at the accepting edge.
   always_comb begin
      op_res = '0;
      op_ill = 1'b0;
      unique case (ALUSignal)
         OpAnd:        op_res = a & b;
         OpOr:         op_res = a | b;
         OpAdd:        op_res = sum;
         OpSub:        op_res = diff;
         OpSlt:        op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OpSll, OpSrl: op_res = b;   // only reached here with shamt == 0
         default:      op_ill = 1'b1;
      endcase
   end

`ifdef ALU_OVF_EN
   // Signed overflow for ADD/SUB; every other op reports 0.
   always_comb begin
      op_ovf = 1'b0;
      if (ALUSignal == OpAdd) begin
         op_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end else if (ALUSignal == OpSub) begin
         op_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
   end
`endif

   // Next-state logic for the FSM, shifter and registered outputs.
   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      cnt_d     = cnt_q;
      dir_d     = dir_q;
      result_d  = result;
      zero_d    = zero;
      illegal_d = illegal;
      busy_d    = busy;
      done_d    = 1'b0;
`ifdef ALU_OVF_EN
      ovf_d     = ovf;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (is_shift && (shamt != '0)) begin
                  sreg_d  = b;
                  dir_d   = ALUSignal[0];
                  cnt_d   = shamt;
                  state_d = StShift;
               end else begin
                  result_d  = op_res;
                  zero_d    = (op_res == '0);
                  illegal_d = op_ill;
                  done_d    = 1'b1;
`ifdef ALU_OVF_EN
                  ovf_d     = op_ovf;
`endif
               end
            end
         end
         StShift: begin
            sreg_d = shifted;
            cnt_d  = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               result_d  = shifted;
               zero_d    = (shifted == '0);
               illegal_d = 1'b0;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = StIdle;
`ifdef ALU_OVF_EN
               ovf_d     = 1'b0;
`endif
            end else begin
               // busy rises on the first shift edge, not the accepting edge
               busy_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers; reset aborts any shift in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         sreg_q  <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         result  <= '0;
         zero    <= 1'b0;
         illegal <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef ALU_OVF_EN
         ovf     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         result  <= result_d;
         zero    <= zero_d;
         illegal <= illegal_d;
         busy    <= busy_d;
         done    <= done_d;
`ifdef ALU_OVF_EN
         ovf     <= ovf_d;
`endif
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: table-driven vectors with an expected-result scoreboard,
// plus hand-written sequences for shifts, ignored starts and reset mid-shift.
module tb_alu_exec_unit;

   logic        clk, rst, start;
   logic [3:0]  ALUSignal;
   logic [31:0] a, b;
   logic [4:0]  shamt;
   logic [31:0] result;
   logic        zero, busy, done, illegal;
   logic        ovf;

   alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ALUSignal (ALUSignal),
      .a         (a),
      .b         (b),
      .shamt     (shamt),
      .result    (result),
      .zero      (zero),
      .busy      (busy),
      .done      (done),
      .illegal   (illegal)
`ifdef ALU_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

`ifndef ALU_OVF_EN
   assign ovf = 1'b0;
`endif

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        ill;
      logic        ov;
   } exp_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] va;
      logic [31:0] vb;
      logic [4:0]  sh;
      logic [31:0] res;
      logic        z;
      logic        ill;
      logic        ov;
   } vec_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_done   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", nm, got, exp);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                        input logic [4:0] sh, input logic [31:0] res, input logic z,
                        input logic ill, input logic ov);
      exp_t e;
      start     = 1'b1;
      ALUSignal = op;
      a         = va;
      b         = vb;
      shamt     = sh;
      e.res = res;
      e.z   = z;
      e.ill = ill;
      e.ov  = ov;
      sb.push_back(e);
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (!rst && done) begin
         n_done++;
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", result, e.res);
            chk("zero", {31'd0, zero}, {31'd0, e.z});
            chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
`ifdef ALU_OVF_EN
            chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
`endif
         end
      end
   end

   vec_t vecs[15];
   int   j, nbusy, d0;

   initial begin
      vecs[0]  = '{4'b0010, 32'd7, 32'd5, 5'd0, 32'd12, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{4'b0110, 32'd5, 32'd5, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{4'b0001, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{4'b0111, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{4'b1111, 32'd5, 32'd3, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0};
      vecs[7]  = '{4'b1000, 32'd0, 32'h1234_ABCD, 5'd0, 32'h1234_ABCD, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{4'b1001, 32'd0, 32'h8000_0001, 5'd0, 32'h8000_0001, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{4'b0110, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{4'b0010, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{4'b0110, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{4'b0010, 32'h8000_0000, 32'h8000_0000, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1};
      vecs[14] = '{4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0};

      rst = 1'b1;
      start = 1'b0;
      ALUSignal = 4'd0;
      a = '0;
      b = '0;
      shamt = '0;
      repeat (2) @(negedge clk);
      chk("rst_result", result, 32'd0);
      chk("rst_flags", {27'd0, zero, busy, done, illegal, ovf}, 32'd0);
      rst = 1'b0;

      // Single-cycle ops, one per clock: each must give done on the next sample.
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (i > 0) chk("b2b_done", {31'd0, done}, 32'd1);
         issue(vecs[i].op, vecs[i].va, vecs[i].vb, vecs[i].sh,
               vecs[i].res, vecs[i].z, vecs[i].ill, vecs[i].ov);
      end
      @(negedge clk);
      chk("b2b_done_last", {31'd0, done}, 32'd1);
      start = 1'b0;
      @(negedge clk);
      chk("done_single_pulse", {31'd0, done}, 32'd0);
      chk("sb_empty_table", sb.size(), 32'd0);

      // SLL by 31: done 31 edges after acceptance, busy for 30 samples.
      issue(4'b1000, 32'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      j = 0;
      nbusy = 0;
      while (!done && j < 40) begin
         if (busy) nbusy++;
         @(negedge clk);
         j++;
      end
      chk("sll31_latency", j, 32'd31);
      chk("sll31_busy_cycles", nbusy, 32'd30);
      chk("sll31_busy_at_done", {31'd0, busy}, 32'd0);
      @(negedge clk);

      // SRL by 4.
      issue(4'b1001, 32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      j = 0;
      while (!done && j < 40) begin
         @(negedge clk);
         j++;
      end
      chk("srl4_latency", j, 32'd4);
      @(negedge clk);

      // A start during SHIFT must be ignored: exactly one done in the window.
      d0 = n_done;
      issue(4'b1001, 32'd0, 32'hF000_0000, 5'd4, 32'h0F00_0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      ALUSignal = 4'b0010;
      a = 32'd1;
      b = 32'd1;
      shamt = 5'd0;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("ignored_start_dones", n_done - d0, 32'd1);
      chk("sb_empty_shift", sb.size(), 32'd0);

      // Reset on the 5th busy cycle of a 20-bit SLL aborts with no done.
      start = 1'b1;
      ALUSignal = 4'b1000;
      b = 32'd1;
      shamt = 5'd20;
      @(negedge clk);
      start = 1'b0;
      nbusy = 0;
      j = 0;
      while (nbusy < 5 && j < 40) begin
         @(negedge clk);
         if (busy) nbusy++;
         j++;
      end
      chk("pre_reset_busy", {31'd0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_result", result, 32'd0);
      chk("midrst_busy_done", {30'd0, busy, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_no_done", {31'd0, done}, 32'd0);
      issue(4'b0010, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      chk("post_rst_done", {31'd0, done}, 32'd1);
      chk("post_rst_result", result, 32'd2);
      repeat (2) @(negedge clk);
      chk("sb_empty_end", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
